// File: rtl/apple_shadow_arbiter_if.sv
// Bus bundle for the banked shadow arbiter: bus write capture,
// per-client read request/response, FIFO status.
interface apple_shadow_arbiter_if #(
    parameter int ADDR_WIDTH   = 14,
    parameter int BANKS        = 2,
    parameter int NUM_RD_PORTS = 2,
    parameter int FIFO_DEPTH   = 8
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic                             wr_strobe_i;
    logic [15:0]                      wr_addr_i;
    logic [BANK_W-1:0]                wr_bank_i;
    logic [7:0]                       wr_data_i;

    logic [NUM_RD_PORTS-1:0]          rd_req_i;
    logic [NUM_RD_PORTS*WORD_W-1:0]   rd_addr_i;
    logic [NUM_RD_PORTS*BANK_W-1:0]   rd_bank_i;
    logic [NUM_RD_PORTS-1:0]          rd_ack_o;
    logic [NUM_RD_PORTS-1:0]          rd_valid_o;
    logic [NUM_RD_PORTS*32-1:0]       rd_data_o;

    logic [LVL_W-1:0]                 fifo_level_o;
    logic                             overflow_o;
    logic                             overflow_clr_i;

    modport master (
        output wr_strobe_i, wr_addr_i, wr_bank_i, wr_data_i,
        output rd_req_i, rd_addr_i, rd_bank_i, overflow_clr_i,
        input  rd_ack_o, rd_valid_o, rd_data_o,
        input  fifo_level_o, overflow_o
    );

    modport slave (
        input  wr_strobe_i, wr_addr_i, wr_bank_i, wr_data_i,
        input  rd_req_i, rd_addr_i, rd_bank_i, overflow_clr_i,
        output rd_ack_o, rd_valid_o, rd_data_o,
        output fifo_level_o, overflow_o
    );
endinterface

// File: rtl/apple_shadow_arbiter.sv
// Banked shadow RAM: bus writes queue in a FIFO and drain into one
// single-port RAM shared round-robin with the video read clients.
module apple_shadow_arbiter #(
    parameter logic [15:0] BASE_ADDR    = 16'h2000,
    parameter int          ADDR_WIDTH   = 14,
    parameter int          BANKS        = 2,
    parameter int          NUM_RD_PORTS = 2,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          HIGH_WATER   = 6
) (
    input  logic                   clk_logic,
    input  logic                   system_reset,
    apple_shadow_arbiter_if.slave  bus
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int WORDS  = 2 ** WORD_W;
    localparam int RAM_W  = BANKS * WORDS;
    localparam int RAM_AW = BANK_W + WORD_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int PORT_W = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int ENT_W  = BANK_W + ADDR_WIDTH + 8;

    logic [ENT_W-1:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [PORT_W-1:0]       rr_q, rr_d;
    logic                    ovf_q, ovf_d;
    logic [NUM_RD_PORTS-1:0] valid_q;
    logic [NUM_RD_PORTS*32-1:0] data_q;
    logic [31:0]             ram_q [RAM_W];

    logic [15:0]             wr_off;
    logic [15:0]             wr_hi;
    logic                    in_range;
    logic                    bank_ok;
    logic                    push_req;
    logic                    full;
    logic                    empty;
    logic                    any_req;
    logic                    wr_slot;
    logic                    push;
    logic                    pop;
    logic                    drop;

    logic [NUM_RD_PORTS-1:0] grant;
    logic [PORT_W-1:0]       gnt_idx;
    logic                    rd_go;
    int                      idx;

    logic [WORD_W-1:0]       rd_word;
    logic [BANK_W-1:0]       rd_bank;
    logic                    rd_ok;
    logic [RAM_AW-1:0]       rd_index;

    logic [ENT_W-1:0]        head;
    logic [BANK_W-1:0]       h_bank;
    logic [ADDR_WIDTH-1:0]   h_off;
    logic [7:0]              h_data;
    logic [RAM_AW-1:0]       w_index;
    logic [3:0]              w_be;
    logic [31:0]             w_data;

    // Window filter works on the wrapped 16-bit offset from the base.
    assign wr_off   = bus.wr_addr_i - BASE_ADDR;
    assign wr_hi    = wr_off >> ADDR_WIDTH;
    assign in_range = (wr_hi == '0);
    assign bank_ok  = (int'(bus.wr_bank_i) < BANKS);
    assign push_req = bus.wr_strobe_i && in_range && bank_ok;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    assign any_req = |bus.rd_req_i;
    assign wr_slot = !empty &&
                     ((int'(level_q) >= HIGH_WATER) || !any_req);

    assign pop  = wr_slot;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        rd_go   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            idx = (int'(rr_q) + i) % NUM_RD_PORTS;
            if (!rd_go && !wr_slot && bus.rd_req_i[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = PORT_W'(idx);
                rd_go      = 1'b1;
            end
        end
    end

    assign rd_word  = bus.rd_addr_i[int'(gnt_idx)*WORD_W +: WORD_W];
    assign rd_bank  = bus.rd_bank_i[int'(gnt_idx)*BANK_W +: BANK_W];
    assign rd_ok    = (int'(rd_bank) < BANKS);
    assign rd_index = {rd_bank, rd_word};

    assign head    = fifo_q[rptr_q];
    assign h_bank  = head[ENT_W-1 -: BANK_W];
    assign h_off   = head[8 +: ADDR_WIDTH];
    assign h_data  = head[7:0];
    assign w_index = {h_bank, h_off[ADDR_WIDTH-1:2]};
    assign w_be    = 4'b0001 << h_off[1:0];
    assign w_data  = {4{h_data}};

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        rr_d = rr_q;
        if (rd_go) begin
            rr_d = PORT_W'((int'(gnt_idx) + 1) % NUM_RD_PORTS);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop || (ovf_q && !bus.overflow_clr_i);
    end

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            valid_q <= grant;
            if (rd_go) begin
                data_q[int'(gnt_idx)*32 +: 32] <=
                    rd_ok ? ram_q[rd_index] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (push) begin
            fifo_q[wptr_q] <= {bus.wr_bank_i,
                               wr_off[ADDR_WIDTH-1:0],
                               bus.wr_data_i};
        end
    end

    always_ff @(posedge clk_logic) begin
        if (pop) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    ram_q[w_index][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.rd_ack_o     = grant & {NUM_RD_PORTS{!system_reset}};
    assign bus.rd_valid_o   = valid_q;
    assign bus.rd_data_o    = data_q;
    assign bus.fifo_level_o = level_q;
    assign bus.overflow_o   = ovf_q;
endmodule
